sync_fifo_fwft: RTL and testbench
=================================

Name:
sync_fifo_fwft

Overview:
- Next-generation single-clock FIFO for the DSA interface path.
- Adds over the current FIFO:
  - selectable standard or first-word-fall-through (FWFT) read mode;
  - programmable almost-full and almost-empty thresholds;
  - overflow/underflow protection with sticky error flags;
  - counts one bit wider, so a completely full FIFO is representable.
- Storage is an internal inferred array with synchronous read; depth is a power of two.

Parameters:
- DATA_WIDTH, 32: word width in bits.
- ADDR_WIDTH, 4: log2 of depth; DEPTH = 2**ADDR_WIDTH.
- FWFT, 0: 0 = standard mode (data one cycle after rd_en); 1 = first-word-fall-through.
- AF_THRESH, DEPTH-2: almost_full asserted when data_count >= AF_THRESH.
- AE_THRESH, 2: almost_empty asserted when data_count <= AE_THRESH.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- wr_en  input  1  write request
- wr_data  input  DATA_WIDTH  write word
- rd_en  input  1  read request (standard) / pop-acknowledge (FWFT)
- rd_data  output  DATA_WIDTH  read word
- rd_valid  output  1  rd_data holds a valid word
- full  output  1  no free entry
- empty  output  1  no readable word
- almost_full  output  1  data_count >= AF_THRESH
- almost_empty  output  1  data_count <= AE_THRESH
- data_count  output  ADDR_WIDTH+1  words held, including any FWFT output-register word
- free_count  output  ADDR_WIDTH+1  DEPTH - data_count
- overflow  output  1  sticky: write attempted while full
- underflow  output  1  sticky: read attempted while empty
- clr_err  input  1  clears overflow/underflow

Behaviour:
- Reset:
  - Synchronous, rst sampled high at a rising edge; overrides all other inputs that cycle.
  - Pointers 0, data_count 0, free_count DEPTH.
  - empty 1, full 0, almost_empty 1, almost_full 0 (AF_THRESH > 0).
  - rd_valid 0, rd_data 0, overflow 0, underflow 0.
  - Reset mid-operation discards all contents; the first write afterwards lands at address 0.
- Accepted write: wr_en & ~full. Word stored at wr_ptr; wr_ptr increments modulo DEPTH (natural wrap).
- Rejected write: wr_en & full. No state change except overflow <= 1.
- Accepted read, standard mode: rd_en & ~empty.
  - rd_ptr advances.
  - Word appears on rd_data with rd_valid=1 after the next edge (latency 1).
  - rd_valid is a one-cycle pulse per accepted read.
  - rd_data holds its last value otherwise.
- Accepted read, FWFT mode: rd_en & rd_valid.
  - Consumes the word on rd_data.
  - The next word, if any, is presented after the following edge(s) without a request.
  - rd_valid stays 1 back-to-back when at least 2 words are held.
  - empty = ~rd_valid.
- Rejected read: rd_en while not readable. No state change except underflow <= 1.
- FWFT latency:
  - A word written at edge k into an empty FIFO is presented with rd_valid=1 from edge k+2.
  - One cycle of RAM read, one cycle into the output register.
  - A prefetch stage keeps the output register full whenever the memory is non-empty.
- Simultaneous write and read:
  - Both accepted when individually legal; data_count unchanged.
  - When full, the write is rejected even if a read is accepted the same cycle; full is registered state.
  - When empty, the read is rejected and the write is accepted.
- Flags:
  - full, empty (standard mode), almost_full and almost_empty are registered.
  - They are computed from next-state count, so they change on the same edge as data_count.
- Counts: data_count ranges 0..DEPTH inclusive; free_count = DEPTH - data_count, always consistent.
- Errors:
  - clr_err clears overflow and underflow at the edge.
  - If a new error occurs in the same cycle as clr_err, set wins.

Test Plan:
1. Standard mode, DEPTH=16. Write 0x00..0x0F over 16 cycles.
   - full=1 after the 16th edge, data_count=16, free_count=0, almost_full from count 14.
   - A 17th write sets overflow=1; contents unchanged.
2. Standard mode. Read all 16 words.
   - Each rd_valid pulse occurs one cycle after its rd_en, data 0x00..0x0F in order.
   - empty=1 after the last read.
   - A further rd_en sets underflow=1 with rd_valid=0.
3. Wrap-around. Keep the FIFO at 3-5 entries while streaming 40 words (0..39) with simultaneous reads/writes.
   - Output order 0..39.
   - data_count stays constant on cycles with both wr_en and rd_en.
4. FWFT=1. Single write of 0xA5 at edge k into an empty FIFO.
   - rd_valid=1, rd_data=0xA5 from edge k+2.
   - rd_en then gives rd_valid=0, empty=1, data_count=0.
   - Back-to-back writes/pops give continuous rd_valid.
5. Full plus simultaneous read/write: wr_en and rd_en together while full.
   - Read accepted, write rejected, overflow=1, data_count=15.
   - clr_err together with a new overflow leaves overflow=1.
6. Assert rst mid-stream with 9 entries held.
   - Next cycle: data_count=0, empty=1, rd_valid=0, flags cleared.
   - A subsequent write of 0x5A is read back as 0x5A.

Source files
------------

// File: rtl/sync_fifo_fwft.sv
// ---------------------------------------------------------------------------
// sync_fifo_fwft : single-clock FIFO, standard or first-word-fall-through read
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_fifo_fwft #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic [ADDR_WIDTH:0]   free_count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   c_DEPTH   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   c_AF      = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0]   c_AE      = (ADDR_WIDTH+1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH:0]   c_CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d, mem_cnt_q, mem_cnt_d;
  logic [DATA_WIDTH-1:0] rd_word_q, out_q;
  logic                  valid_q, valid_d, stg_valid_q, stg_valid_d;
  logic                  full_q, empty_q, af_q, ae_q, ovf_q, udf_q;
  logic                  ovf_d, udf_d;
  logic                  wr_acc, rd_acc, readable, out_load, launch, mem_rd;

  always_comb begin
    wr_acc   = wr_en & ~full_q;
    readable = (FWFT != 0) ? valid_q : ~empty_q;
    rd_acc   = rd_en & readable;
    // In FWFT mode rd_word_q is a prefetch stage feeding the output register.
    out_load = (FWFT != 0) & stg_valid_q & (~valid_q | rd_acc);
    launch   = (mem_cnt_q != '0) & (~stg_valid_q | out_load);
    mem_rd   = (FWFT != 0) ? launch : rd_acc;

    wr_ptr_d = wr_acc ? wr_ptr_q + c_PTR_ONE : wr_ptr_q;
    rd_ptr_d = mem_rd ? rd_ptr_q + c_PTR_ONE : rd_ptr_q;

    cnt_d = cnt_q;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + c_CNT_ONE;
      2'b01:   cnt_d = cnt_q - c_CNT_ONE;
      default: cnt_d = cnt_q;
    endcase

    mem_cnt_d = mem_cnt_q;
    case ({wr_acc, mem_rd})
      2'b10:   mem_cnt_d = mem_cnt_q + c_CNT_ONE;
      2'b01:   mem_cnt_d = mem_cnt_q - c_CNT_ONE;
      default: mem_cnt_d = mem_cnt_q;
    endcase

    valid_d     = rd_acc;
    stg_valid_d = 1'b0;
    if (FWFT != 0) begin
      valid_d     = out_load ? 1'b1 : (rd_acc ? 1'b0 : valid_q);
      stg_valid_d = mem_rd ? 1'b1 : (out_load ? 1'b0 : stg_valid_q);
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    ovf_d = (wr_en & full_q) | (ovf_q & ~clr_err);
    udf_d = (rd_en & ~readable) | (udf_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      mem_cnt_q   <= '0;
      rd_word_q   <= '0;
      out_q       <= '0;
      valid_q     <= 1'b0;
      stg_valid_q <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      mem_cnt_q   <= mem_cnt_d;
      valid_q     <= valid_d;
      stg_valid_q <= stg_valid_d;
      full_q      <= (cnt_d == c_DEPTH);
      empty_q     <= (cnt_d == '0);
      af_q        <= (cnt_d >= c_AF);
      ae_q        <= (cnt_d <= c_AE);
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      if (mem_rd) begin
        rd_word_q <= mem_q[rd_ptr_q];
      end
      if (out_load) begin
        out_q <= rd_word_q;
      end
    end
  end

  assign rd_data      = (FWFT != 0) ? out_q : rd_word_q;
  assign rd_valid     = valid_q;
  assign full         = full_q;
  assign empty        = (FWFT != 0) ? ~valid_q : empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign data_count   = cnt_q;
  assign free_count   = c_DEPTH - cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_fwft.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_fwft : directed bench for a standard-mode and an FWFT instance
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sync_fifo_fwft;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        s_rst, s_wr_en, s_rd_en, s_clr;
  logic [31:0] s_wr_data, s_rd_data;
  logic        s_rd_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic [4:0]  s_cnt, s_free;

  logic        f_rst, f_wr_en, f_rd_en, f_clr;
  logic [31:0] f_wr_data, f_rd_data;
  logic        f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [4:0]  f_cnt, f_free;

  sync_fifo_fwft #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .FWFT(0)) u_std (
    .clk(clk), .rst(s_rst), .wr_en(s_wr_en), .wr_data(s_wr_data), .rd_en(s_rd_en),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .data_count(s_cnt), .free_count(s_free),
    .overflow(s_ovf), .underflow(s_udf), .clr_err(s_clr)
  );

  sync_fifo_fwft #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .FWFT(1)) u_fwft (
    .clk(clk), .rst(f_rst), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .data_count(f_cnt), .free_count(f_free),
    .overflow(f_ovf), .underflow(f_udf), .clr_err(f_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    s_rst = 1'b1; f_rst = 1'b1;
    tick(); tick();
    s_rst = 1'b0; f_rst = 1'b0;
    checks++;
    if ({s_cnt, s_free} !== {5'd0, 5'd16}) begin
      failures++; $display("FAIL std_reset_counts got=%h exp=%h", {s_cnt, s_free}, {5'd0, 5'd16});
    end
    checks++;
    if ({s_empty, s_full, s_ae, s_af} !== 4'b1010) begin
      failures++; $display("FAIL std_reset_flags got=%b exp=1010", {s_empty, s_full, s_ae, s_af});
    end
    checks++;
    if ({s_rd_valid, s_ovf, s_udf, s_rd_data} !== 35'd0) begin
      failures++; $display("FAIL std_reset_out got=%h exp=0", {s_rd_valid, s_ovf, s_udf, s_rd_data});
    end
    checks++;
    if ({f_cnt, f_free, f_empty, f_full, f_ae, f_af} !== {5'd0, 5'd16, 4'b1010}) begin
      failures++; $display("FAIL fwft_reset_state got=%h exp=%h",
                           {f_cnt, f_free, f_empty, f_full, f_ae, f_af}, {5'd0, 5'd16, 4'b1010});
    end
    checks++;
    if ({f_rd_valid, f_ovf, f_udf, f_rd_data} !== 35'd0) begin
      failures++; $display("FAIL fwft_reset_out got=%h exp=0", {f_rd_valid, f_ovf, f_udf, f_rd_data});
    end
  endtask

  task automatic test_std_fill();
    for (int i = 0; i < 16; i++) begin
      s_wr_en = 1'b1; s_wr_data = i;
      tick();
      checks++;
      if (s_cnt !== 5'(i + 1) || s_free !== 5'(15 - i)) begin
        failures++; $display("FAIL fill_count[%0d] got=%0d/%0d exp=%0d/%0d", i, s_cnt, s_free, i + 1, 15 - i);
      end
      checks++;
      if ({s_full, s_af, s_ae} !== {(i == 15), (i >= 13), (i <= 1)}) begin
        failures++; $display("FAIL fill_flags[%0d] got=%b exp=%b", i, {s_full, s_af, s_ae},
                             {(i == 15), (i >= 13), (i <= 1)});
      end
    end
    s_wr_data = 32'hFF;
    tick();
    s_wr_en = 1'b0;
    checks++;
    if ({s_ovf, s_full, s_cnt, s_free} !== {2'b11, 5'd16, 5'd0}) begin
      failures++; $display("FAIL fill_overflow got=%h exp=%h", {s_ovf, s_full, s_cnt, s_free}, {2'b11, 5'd16, 5'd0});
    end
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    checks++;
    if (s_ovf !== 1'b0) begin
      failures++; $display("FAIL clr_overflow got=%b exp=0", s_ovf);
    end
  endtask

  task automatic test_std_drain();
    s_rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (s_rd_valid !== 1'b1 || s_rd_data !== 32'(i)) begin
        failures++; $display("FAIL drain_data[%0d] got=%b/%h exp=1/%h", i, s_rd_valid, s_rd_data, i);
      end
    end
    s_rd_en = 1'b0;
    tick();
    checks++;
    if ({s_rd_valid, s_empty, s_cnt, s_rd_data} !== {2'b01, 5'd0, 32'h0F}) begin
      failures++; $display("FAIL drain_end got=%h exp=%h", {s_rd_valid, s_empty, s_cnt, s_rd_data},
                           {2'b01, 5'd0, 32'h0F});
    end
    s_rd_en = 1'b1;
    tick();
    s_rd_en = 1'b0;
    checks++;
    if ({s_udf, s_rd_valid} !== 2'b10) begin
      failures++; $display("FAIL underflow got=%b exp=10", {s_udf, s_rd_valid});
    end
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
  endtask

  task automatic test_wrap();
    int  mcnt, nw, nr;
    logic do_w, do_r;
    mcnt = 0; nw = 0; nr = 0;
    for (int i = 0; i < 4; i++) begin
      s_wr_en = 1'b1; s_wr_data = nw;
      tick();
      nw++; mcnt++;
    end
    for (int j = 0; j < 200 && nr < 40; j++) begin
      do_w = (nw < 40) && (j % 4 != 3);
      do_r = (mcnt > 0) && ((j % 4 != 1) || (nw >= 40));
      s_wr_en = do_w; s_wr_data = nw; s_rd_en = do_r;
      tick();
      if (do_w) begin nw++; mcnt++; end
      if (do_r) mcnt--;
      checks++;
      if (s_cnt !== 5'(mcnt)) begin
        failures++; $display("FAIL wrap_count[%0d] got=%0d exp=%0d", j, s_cnt, mcnt);
      end
      if (do_r) begin
        checks++;
        if (s_rd_valid !== 1'b1 || s_rd_data !== 32'(nr)) begin
          failures++; $display("FAIL wrap_data[%0d] got=%b/%0d exp=1/%0d", j, s_rd_valid, s_rd_data, nr);
        end
        nr++;
      end
    end
    s_wr_en = 1'b0; s_rd_en = 1'b0;
    checks++;
    if ({s_empty, s_cnt} !== {1'b1, 5'd0}) begin
      failures++; $display("FAIL wrap_end got=%h exp=%h", {s_empty, s_cnt}, {1'b1, 5'd0});
    end
  endtask

  task automatic test_fwft_single();
    f_wr_en = 1'b1; f_wr_data = 32'hA5;
    tick();
    f_wr_en = 1'b0;
    checks++;
    if ({f_rd_valid, f_empty, f_cnt} !== {2'b01, 5'd1}) begin
      failures++; $display("FAIL fwft_k got=%h exp=%h", {f_rd_valid, f_empty, f_cnt}, {2'b01, 5'd1});
    end
    tick();
    checks++;
    if (f_rd_valid !== 1'b0) begin
      failures++; $display("FAIL fwft_k1_valid got=%b exp=0", f_rd_valid);
    end
    tick();
    checks++;
    if ({f_rd_valid, f_empty, f_rd_data} !== {2'b10, 32'hA5}) begin
      failures++; $display("FAIL fwft_k2 got=%h exp=%h", {f_rd_valid, f_empty, f_rd_data}, {2'b10, 32'hA5});
    end
    f_rd_en = 1'b1;
    tick();
    f_rd_en = 1'b0;
    checks++;
    if ({f_rd_valid, f_empty, f_cnt} !== {2'b01, 5'd0}) begin
      failures++; $display("FAIL fwft_pop got=%h exp=%h", {f_rd_valid, f_empty, f_cnt}, {2'b01, 5'd0});
    end
    f_rd_en = 1'b1;
    tick();
    f_rd_en = 1'b0;
    checks++;
    if ({f_udf, f_rd_valid} !== 2'b10) begin
      failures++; $display("FAIL fwft_underflow got=%b exp=10", {f_udf, f_rd_valid});
    end
    f_clr = 1'b1;
    tick();
    f_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      f_wr_en = 1'b1; f_wr_data = 32'h10 + i;
      tick();
    end
    f_wr_en = 1'b0;
    repeat (4) tick();
    for (int n = 0; n < 11; n++) begin
      checks++;
      if (f_rd_valid !== 1'b1 || f_rd_data !== 32'h10 + n) begin
        failures++; $display("FAIL b2b_data[%0d] got=%b/%h exp=1/%h", n, f_rd_valid, f_rd_data, 32'h10 + n);
      end
      checks++;
      if (f_cnt !== ((n < 8) ? 5'd3 : 5'(11 - n))) begin
        failures++; $display("FAIL b2b_count[%0d] got=%0d exp=%0d", n, f_cnt, (n < 8) ? 3 : 11 - n);
      end
      f_rd_en = 1'b1; f_wr_en = (n < 8); f_wr_data = 32'h13 + n;
      tick();
    end
    f_rd_en = 1'b0; f_wr_en = 1'b0;
    checks++;
    if ({f_rd_valid, f_empty, f_cnt} !== {2'b01, 5'd0}) begin
      failures++; $display("FAIL b2b_end got=%h exp=%h", {f_rd_valid, f_empty, f_cnt}, {2'b01, 5'd0});
    end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 16; i++) begin
      s_wr_en = 1'b1; s_wr_data = 32'h20 + i;
      tick();
    end
    s_wr_data = 32'h99; s_rd_en = 1'b1;
    tick();
    s_rd_en = 1'b0;
    checks++;
    if ({s_rd_valid, s_ovf, s_full, s_cnt} !== {3'b110, 5'd15} || s_rd_data !== 32'h20) begin
      failures++; $display("FAIL full_rw got=%h/%h exp=%h/20", {s_rd_valid, s_ovf, s_full, s_cnt},
                           s_rd_data, {3'b110, 5'd15});
    end
    s_wr_data = 32'h30;
    tick();
    s_clr = 1'b1;
    tick();
    checks++;
    if ({s_ovf, s_cnt} !== {1'b1, 5'd16}) begin
      failures++; $display("FAIL clr_vs_set got=%h exp=%h", {s_ovf, s_cnt}, {1'b1, 5'd16});
    end
    s_wr_en = 1'b0; s_clr = 1'b0;
  endtask

  task automatic test_mid_reset();
    s_rd_en = 1'b1;
    repeat (7) tick();
    s_rd_en = 1'b0;
    checks++;
    if (s_cnt !== 5'd9) begin
      failures++; $display("FAIL pre_reset_count got=%0d exp=9", s_cnt);
    end
    s_rst = 1'b1; s_wr_en = 1'b1; s_wr_data = 32'h77;
    tick();
    s_rst = 1'b0; s_wr_en = 1'b0;
    checks++;
    if ({s_cnt, s_free, s_empty, s_full, s_ae, s_af} !== {5'd0, 5'd16, 4'b1010}) begin
      failures++; $display("FAIL mid_reset_state got=%h exp=%h",
                           {s_cnt, s_free, s_empty, s_full, s_ae, s_af}, {5'd0, 5'd16, 4'b1010});
    end
    checks++;
    if ({s_rd_valid, s_ovf, s_udf} !== 3'b000) begin
      failures++; $display("FAIL mid_reset_flags got=%b exp=000", {s_rd_valid, s_ovf, s_udf});
    end
    s_wr_en = 1'b1; s_wr_data = 32'h5A;
    tick();
    s_wr_en = 1'b0; s_rd_en = 1'b1;
    tick();
    s_rd_en = 1'b0;
    checks++;
    if (s_rd_valid !== 1'b1 || s_rd_data !== 32'h5A) begin
      failures++; $display("FAIL post_reset_read got=%b/%h exp=1/5a", s_rd_valid, s_rd_data);
    end
  endtask

  initial begin
    s_rst = 1'b1; s_wr_en = 1'b0; s_rd_en = 1'b0; s_clr = 1'b0; s_wr_data = '0;
    f_rst = 1'b1; f_wr_en = 1'b0; f_rd_en = 1'b0; f_clr = 1'b0; f_wr_data = '0;
    test_reset();
    test_std_fill();
    test_std_drain();
    test_wrap();
    test_fwft_single();
    test_back_to_back();
    test_full_rw();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
